// File: rtl/skew_feeder.sv
// Skew feeder: staggers weight and activation beats into a systolic PE array, then flushes zeros through the chains.
// Optional SKEW_FEEDER_BEAT_CNT_EN adds a saturating 16-bit beat_count output.
module skew_feeder #(
  parameter int ROWS = 16,
  parameter int COLS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [0:8*ROWS-1]   in_w_vec,
  input  logic [0:8*COLS-1]   in_a_vec,
  output logic [0:8*ROWS-1]   out_w_port,
  output logic [0:8*COLS-1]   out_a_port,
  output logic                fire,
  output logic                busy,
  output logic                done
`ifdef SKEW_FEEDER_BEAT_CNT_EN
  ,
  output logic [15:0]         beat_count
`endif
);

  localparam int FLUSH_LEN = ROWS + COLS - 1;
  localparam int CNT_W     = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] flush_cnt_reg;
  logic             fire_reg;
  logic             done_reg;

  logic accept;
  logic flushing;
  logic advance;

  assign in_ready = (state_reg == IDLE) || (state_reg == STREAM);
  assign busy     = (state_reg == STREAM) || (state_reg == FLUSH);
  assign accept   = in_valid && in_ready;
  assign flushing = (state_reg == FLUSH);
  assign advance  = accept || flushing;
  assign fire     = fire_reg;
  assign done     = done_reg;

  // Control: flush counter is loaded with FLUSH_LEN-1 so FLUSH spans FLUSH_LEN cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      flush_cnt_reg <= '0;
      fire_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      fire_reg <= advance;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, STREAM: begin
          if (accept) begin
            if (in_last) begin
              state_reg     <= FLUSH;
              flush_cnt_reg <= CNT_W'(FLUSH_LEN - 1);
            end else begin
              state_reg <= STREAM;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt_reg == '0) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - CNT_W'(1);
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Lane k gets a k+1 deep chain; zeros are injected while flushing.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_w_lane
    logic [7:0] stage_reg [0:gi];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s <= gi; s++) stage_reg[s] <= 8'h00;
      end else if (advance) begin
        stage_reg[0] <= flushing ? 8'h00 : in_w_vec[8*gi +: 8];
        for (int s = 1; s <= gi; s++) stage_reg[s] <= stage_reg[s-1];
      end
    end
    assign out_w_port[8*gi +: 8] = stage_reg[gi];
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_a_lane
    logic [7:0] stage_reg [0:gi];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s <= gi; s++) stage_reg[s] <= 8'h00;
      end else if (advance) begin
        stage_reg[0] <= flushing ? 8'h00 : in_a_vec[8*gi +: 8];
        for (int s = 1; s <= gi; s++) stage_reg[s] <= stage_reg[s-1];
      end
    end
    assign out_a_port[8*gi +: 8] = stage_reg[gi];
  end

`ifdef SKEW_FEEDER_BEAT_CNT_EN
  logic [15:0] beat_count_reg;

  // First beat accepted in IDLE restarts the count at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count_reg <= 16'd0;
    end else if (accept) begin
      if (state_reg == IDLE)
        beat_count_reg <= 16'd1;
      else if (beat_count_reg != 16'hFFFF)
        beat_count_reg <= beat_count_reg + 16'd1;
    end
  end

  assign beat_count = beat_count_reg;
`endif

endmodule

// File: tb/tb_skew_feeder.sv
// Randomized bench for skew_feeder (ROWS=COLS=4) against a history-based reference model.
module tb_skew_feeder;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int FLUSH_LEN = ROWS + COLS - 1;

  typedef logic [0:8*ROWS-1] vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_last;
  vec_t in_w_vec, in_a_vec, out_w_port, out_a_port;
  logic fire, busy, done;
`ifdef SKEW_FEEDER_BEAT_CNT_EN
  logic [15:0] beat_count;
`endif

  always #5 clk = ~clk;

  skew_feeder #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_w_vec(in_w_vec), .in_a_vec(in_a_vec),
    .out_w_port(out_w_port), .out_a_port(out_a_port),
    .fire(fire), .busy(busy), .done(done)
`ifdef SKEW_FEEDER_BEAT_CNT_EN
    , .beat_count(beat_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every advance records the byte vector entering stage 0;
  // lane k shows the entry recorded k+1 advances ago (zero if none since reset).
  vec_t hw[$];
  vec_t ha[$];
  int   m_state;      // 0 idle, 1 stream, 2 flush, 3 done
  int   m_flush_left;
  bit   m_fire, m_done;
  int   m_cnt;

  task automatic model_clear();
    hw.delete(); ha.delete();
    m_state = 0; m_flush_left = 0; m_fire = 0; m_done = 0; m_cnt = 0;
  endtask

  function automatic vec_t model_out(input bit use_w);
    vec_t r, e;
    int n;
    r = '0;
    n = use_w ? hw.size() : ha.size();
    for (int k = 0; k < ROWS; k++) begin
      if (n >= k + 1) begin
        e = use_w ? hw[n-k-1] : ha[n-k-1];
        r[8*k +: 8] = e[8*k +: 8];
      end
    end
    return r;
  endfunction

  task automatic model_update(input logic v, input logic l, input vec_t w, input vec_t a);
    bit acc, fl;
    acc = v && (m_state < 2);
    fl  = (m_state == 2);
    m_fire = acc || fl;
    if (acc) begin hw.push_back(w); ha.push_back(a); end
    else if (fl) begin hw.push_back('0); ha.push_back('0); end
    while (hw.size() > 2*ROWS) begin void'(hw.pop_front()); void'(ha.pop_front()); end
    m_done = 0;
    case (m_state)
      0, 1: if (acc) begin
        if (m_state == 0) m_cnt = 1;
        else if (m_cnt < 65535) m_cnt++;
        if (l) begin m_state = 2; m_flush_left = FLUSH_LEN; end
        else m_state = 1;
      end
      2: begin
        m_flush_left--;
        if (m_flush_left == 0) begin m_state = 3; m_done = 1; end
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic check_outputs();
    check("in_ready", 64'(in_ready), 64'(m_state < 2));
    check("busy",     64'(busy),     64'(m_state == 1 || m_state == 2));
    check("done",     64'(done),     64'(m_done));
    check("fire",     64'(fire),     64'(m_fire));
    check("out_w",    64'(out_w_port), 64'(model_out(1'b1)));
    check("out_a",    64'(out_a_port), 64'(model_out(1'b0)));
`ifdef SKEW_FEEDER_BEAT_CNT_EN
    check("beat_count", 64'(beat_count), 64'(m_cnt));
`endif
  endtask

  // Called at posedge+1: drive, check at negedge, update model at posedge.
  task automatic cycle(input logic v, input logic l, input vec_t w, input vec_t a);
    in_valid = v; in_last = l; in_w_vec = w; in_a_vec = a;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update(v, l, w, a);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, vec_t'($urandom), vec_t'($urandom));
  endtask

  task automatic reset_mid();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_out_w", 64'(out_w_port), 64'd0);
    check("rst_out_a", 64'(out_a_port), 64'd0);
    check("rst_fire",  64'(fire), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  vec_t v1, v2;
  int   len;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_w_vec = '0; in_a_vec = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    v1 = 32'h01020304;
    v2 = 32'h05060708;

    // Two-beat stream, continuous valid
    cycle(1'b1, 1'b0, v1, v1);
    cycle(1'b1, 1'b1, v2, v2);
    idle(FLUSH_LEN + 3);

    // Same stream with a 3-cycle bubble
    cycle(1'b1, 1'b0, v1, v1);
    idle(3);
    cycle(1'b1, 1'b1, v2, v2);
    idle(FLUSH_LEN + 3);

    // Single last beat straight from IDLE
    cycle(1'b1, 1'b1, v1, v2);
    idle(FLUSH_LEN + 2);

    // Valid held high with changing data through FLUSH and DONE
    cycle(1'b1, 1'b0, v2, v1);
    cycle(1'b1, 1'b1, v1, v2);
    for (int i = 0; i < FLUSH_LEN + 1; i++) cycle(1'b1, 1'b0, vec_t'($urandom), vec_t'($urandom));
    idle(2);

    // Reset during flush cycle 3
    cycle(1'b1, 1'b0, v1, v1);
    cycle(1'b1, 1'b1, v2, v2);
    idle(2);
    reset_mid();
    idle(2);

    // Five-beat stream followed by a new stream
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0 + (i == 4), vec_t'($urandom), vec_t'($urandom));
    idle(FLUSH_LEN + 2);
    cycle(1'b1, 1'b0, v1, v2);
    cycle(1'b1, 1'b1, v2, v1);
    idle(FLUSH_LEN + 2);

    // Randomized streams with bubbles, junk during flush, occasional reset
    for (int s = 0; s < 40; s++) begin
      len = int'($urandom_range(1, 6));
      for (int b = 0; b < len; b++) begin
        idle(int'($urandom_range(0, 3)) * int'($urandom_range(0, 1)));
        cycle(1'b1, 1'(b == len - 1), vec_t'($urandom), vec_t'($urandom));
      end
      if ($urandom_range(0, 7) == 0) begin
        idle(2);
        reset_mid();
      end else begin
        for (int i = 0; i < FLUSH_LEN + 1; i++)
          cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), vec_t'($urandom), vec_t'($urandom));
      end
      idle(int'($urandom_range(0, 2)));
    end
    idle(FLUSH_LEN + 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
